// File: rtl/cpu_pkg.sv
// Types shared by the register file, decoder and sequencer.
package cpu_pkg;

   typedef enum logic [3:0] {
      R_Z, R_W, R_B, R_C, R_D, R_E, R_H, R_L,
      R_SPH, R_SPL, R_PCH, R_PCL, R_A, R_F,
      R_MEM, R_X
   } reg8_t;

   typedef enum logic [2:0] {
      RR_WZ, RR_BC, RR_DE, RR_HL,
      RR_AF, RR_SP, RR_PC, RR_PCH_ZERO
   } reg16_t;

   typedef enum logic [1:0] {
      IDU_INC, IDU_DEC, IDU_ADJ
   } idu_mode_t;

   typedef enum logic [1:0] {
      WB_NONE, WB_IDU, WB_WZ
   } s_rr_wb_t;

   typedef struct packed {
      logic z;
      logic n;
      logic h;
      logic c;
   } flags_t;

   localparam logic [7:0] F_LOW_MASK = 8'hF0;

   function automatic reg8_t pair_hi(reg16_t p);
      case (p)
         RR_WZ:   pair_hi = R_W;
         RR_BC:   pair_hi = R_B;
         RR_DE:   pair_hi = R_D;
         RR_HL:   pair_hi = R_H;
         RR_AF:   pair_hi = R_A;
         RR_SP:   pair_hi = R_SPH;
         default: pair_hi = R_PCH;
      endcase
   endfunction

   function automatic reg8_t pair_lo(reg16_t p);
      case (p)
         RR_WZ:   pair_lo = R_Z;
         RR_BC:   pair_lo = R_C;
         RR_DE:   pair_lo = R_E;
         RR_HL:   pair_lo = R_L;
         RR_AF:   pair_lo = R_F;
         RR_SP:   pair_lo = R_SPL;
         default: pair_lo = R_PCL;
      endcase
   endfunction

endpackage

// File: rtl/cpu_regfile_idu.sv
// 16-bit increment/decrement unit, including the relative-jump PCH adjust.
module cpu_regfile_idu
   import cpu_pkg::*;
(
   input  logic [15:0] addr,
   input  idu_mode_t   idu,
   input  logic [7:0]  pch,
   input  logic        z7,
   input  logic        adj_carry,
   output logic [15:0] result
);

   logic [7:0] adj;

   always_comb begin
      adj = 8'h00;
      if (adj_carry && !z7) begin
         adj = 8'h01;
      end else if (!adj_carry && z7) begin
         adj = 8'hFF;
      end
      case (idu)
         IDU_DEC: result = addr - 16'd1;
         IDU_ADJ: result = {pch + adj, 8'h00};
         default: result = addr + 16'd1;
      endcase
   end

endmodule

// File: rtl/cpu_regfile.sv
// Register file: 8-bit storage, pair address bus, IDU writeback and PC update.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter logic [15:0] SP_RESET = 16'hFFFE,
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  reg16_t      s_ab,
   input  reg8_t       s_db,
   input  reg8_t       t_db,
   input  logic [7:0]  wr_data,
   input  idu_mode_t   idu,
   input  s_rr_wb_t    s_rr_wb,
   input  reg16_t      t_rr_wb,
   input  logic        wr_pc,
   input  logic        adj_carry,
   input  logic        flags_we,
   input  flags_t      flags_in,
   output logic [15:0] addr,
   output logic [7:0]  rd_data,
   output logic        mem_we,
   output flags_t      flags,
   output logic [15:0] pc
);

   logic [15:0][7:0] r_q;
   logic [15:0][7:0] r_d;
   logic [15:0]      idu_res;
   logic [15:0]      wb_val;
   logic             wb_en;

   assign addr = {r_q[pair_hi(s_ab)],
                  (s_ab == RR_PCH_ZERO) ? 8'h00 : r_q[pair_lo(s_ab)]};

   assign rd_data = (s_db == R_MEM || s_db == R_X) ? 8'h00 : r_q[s_db];
   assign mem_we  = rst && (t_db == R_MEM);
   assign flags   = r_q[R_F][7:4];
   assign pc      = {r_q[R_PCH], r_q[R_PCL]};

   cpu_regfile_idu u_idu (
      .addr      (addr),
      .idu       (idu),
      .pch       (r_q[R_PCH]),
      .z7        (r_q[R_Z][7]),
      .adj_carry (adj_carry),
      .result    (idu_res)
   );

   assign wb_en  = (s_rr_wb != WB_NONE) && (t_rr_wb != RR_PCH_ZERO);
   assign wb_val = (s_rr_wb == WB_IDU) ? idu_res : {r_q[R_W], r_q[R_Z]};

   // Later assignments win: flags < pair < data bus < PC.
   always_comb begin
      r_d = r_q;
      if (flags_we) begin
         r_d[R_F] = {flags_in, 4'h0};
      end
      if (wb_en) begin
         r_d[pair_hi(t_rr_wb)] = wb_val[15:8];
         r_d[pair_lo(t_rr_wb)] = wb_val[7:0];
      end
      if (t_db != R_MEM && t_db != R_X) begin
         r_d[t_db] = wr_data;
      end
      if (wr_pc) begin
         r_d[R_PCH] = idu_res[15:8];
         r_d[R_PCL] = idu_res[7:0];
      end
      r_d[R_F] = r_d[R_F] & F_LOW_MASK;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q        <= '0;
         r_q[R_SPH] <= SP_RESET[15:8];
         r_q[R_SPL] <= SP_RESET[7:0];
         r_q[R_PCH] <= PC_RESET[15:8];
         r_q[R_PCL] <= PC_RESET[7:0];
      end else begin
         r_q <= r_d;
      end
   end

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed plan steps then random cycles against a byte-array reference model.
module tb_cpu_regfile;
   import cpu_pkg::*;

   logic        clk;
   logic        rst;
   reg16_t      s_ab;
   reg8_t       s_db;
   reg8_t       t_db;
   logic [7:0]  wr_data;
   idu_mode_t   idu;
   s_rr_wb_t    s_rr_wb;
   reg16_t      t_rr_wb;
   logic        wr_pc;
   logic        adj_carry;
   logic        flags_we;
   flags_t      flags_in;
   logic [15:0] addr;
   logic [7:0]  rd_data;
   logic        mem_we;
   flags_t      flags;
   logic [15:0] pc;

   int errors = 0;
   int checks = 0;
   logic [7:0] m [14];

   cpu_regfile dut (
      .clk(clk), .rst(rst), .s_ab(s_ab), .s_db(s_db), .t_db(t_db),
      .wr_data(wr_data), .idu(idu), .s_rr_wb(s_rr_wb),
      .t_rr_wb(t_rr_wb), .wr_pc(wr_pc), .adj_carry(adj_carry),
      .flags_we(flags_we), .flags_in(flags_in), .addr(addr),
      .rd_data(rd_data), .mem_we(mem_we), .flags(flags), .pc(pc)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int hi_i(reg16_t p);
      case (p)
         RR_WZ: return 1;
         RR_BC: return 2;
         RR_DE: return 4;
         RR_HL: return 6;
         RR_AF: return 12;
         RR_SP: return 8;
         default: return 10;
      endcase
   endfunction

   function automatic int lo_i(reg16_t p);
      case (p)
         RR_WZ: return 0;
         RR_BC: return 3;
         RR_DE: return 5;
         RR_HL: return 7;
         RR_AF: return 13;
         RR_SP: return 9;
         default: return 11;
      endcase
   endfunction

   function automatic int m_addr(reg16_t p);
      if (p == RR_PCH_ZERO) return int'(m[10]) * 256;
      return int'(m[hi_i(p)]) * 256 + int'(m[lo_i(p)]);
   endfunction

   function automatic int m_idu();
      int a, adj;
      a = m_addr(s_ab);
      if (idu == IDU_INC) return (a + 1) % 65536;
      if (idu == IDU_DEC) return (a + 65535) % 65536;
      adj = 0;
      if (adj_carry && m[0] < 128) adj = 1;
      if (!adj_carry && m[0] >= 128) adj = -1;
      return ((int'(m[10]) + adj + 256) % 256) * 256;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 14; i++) m[i] = 8'h00;
      m[8] = 8'hFF;
      m[9] = 8'hFE;
   endtask

   task automatic model_edge();
      logic [7:0] n [14];
      int res, v;
      if (!rst) begin
         model_reset();
         return;
      end
      n = m;
      res = m_idu();
      if (flags_we) n[13] = {flags_in, 4'h0};
      if (s_rr_wb != WB_NONE && t_rr_wb != RR_PCH_ZERO) begin
         v = (s_rr_wb == WB_IDU) ? res
                                 : int'(m[1]) * 256 + int'(m[0]);
         n[hi_i(t_rr_wb)] = 8'(v / 256);
         n[lo_i(t_rr_wb)] = 8'(v % 256);
      end
      if (int'(t_db) < 14) n[int'(t_db)] = wr_data;
      if (wr_pc) begin
         n[10] = 8'(res / 256);
         n[11] = 8'(res % 256);
      end
      n[13] = n[13] & 8'hF0;
      m = n;
   endtask

   task automatic idle();
      s_ab = RR_PC; s_db = R_MEM; t_db = R_X; wr_data = 8'h00;
      idu = IDU_INC; s_rr_wb = WB_NONE; t_rr_wb = RR_WZ;
      wr_pc = 1'b0; adj_carry = 1'b0; flags_we = 1'b0;
      flags_in = 4'h0;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set8(reg8_t r, logic [7:0] v);
      idle();
      t_db = r;
      wr_data = v;
      tick();
   endtask

   task automatic rd8(reg8_t r, output logic [7:0] v);
      s_db = r;
      #1;
      v = rd_data;
   endtask

   task automatic rd16(reg16_t p, output logic [15:0] v);
      s_ab = p;
      #1;
      v = addr;
   endtask

   task automatic check_all(string tag);
      logic [7:0] b;
      logic [15:0] w;
      idle();
      for (int i = 0; i < 14; i++) begin
         rd8(reg8_t'(4'(i)), b);
         chk($sformatf("%s.r%0d", tag, i), {8'h00, b}, {8'h00, m[i]});
      end
      for (int i = 0; i < 8; i++) begin
         rd16(reg16_t'(3'(i)), w);
         chk($sformatf("%s.p%0d", tag, i), w, 16'(m_addr(reg16_t'(3'(i)))));
      end
      chk({tag, ".pc"}, pc, {m[10], m[11]});
      chk({tag, ".flags"}, {12'h0, flags}, {12'h0, m[13][7:4]});
   endtask

   logic [7:0]  v8;
   logic [15:0] v16;

   initial begin
      idle();
      rst = 1'b0;
      model_reset();
      t_db = R_MEM;
      #1;
      chk("rst.mem_we", {15'h0, mem_we}, 16'h0);
      t_db = R_X;
      tick();
      tick();
      rst = 1'b1;
      check_all("rst");
      chk("rst.pc", pc, 16'h0000);
      rd16(RR_SP, v16);
      chk("rst.sp", v16, 16'hFFFE);

      set8(R_PCH, 8'h01);
      set8(R_PCL, 8'h00);
      set8(R_Z, 8'h34);
      set8(R_W, 8'h12);
      idle();
      s_ab = RR_PC; s_rr_wb = WB_WZ; t_rr_wb = RR_BC; wr_pc = 1'b1;
      tick();
      rd16(RR_BC, v16);
      chk("ldbc.bc", v16, 16'h1234);
      chk("ldbc.pc", pc, 16'h0101);
      check_all("ldbc");

      set8(R_H, 8'hFF);
      set8(R_L, 8'hFF);
      idle();
      s_ab = RR_HL; idu = IDU_INC; s_rr_wb = WB_IDU; t_rr_wb = RR_HL;
      t_db = R_Z; wr_data = 8'h5A;
      tick();
      rd16(RR_HL, v16);
      chk("hlwrap.hl", v16, 16'h0000);
      rd8(R_Z, v8);
      chk("hlwrap.z", {8'h0, v8}, 16'h005A);

      set8(R_PCH, 8'h12);
      set8(R_PCL, 8'hF0);
      set8(R_Z, 8'h20);
      idle();
      s_ab = RR_PCH_ZERO; idu = IDU_ADJ; adj_carry = 1'b1;
      s_rr_wb = WB_IDU; t_rr_wb = RR_WZ; t_db = R_Z; wr_data = 8'h10;
      #1;
      chk("jr.addr", addr, 16'h1200);
      tick();
      rd8(R_W, v8);
      chk("jr1.w", {8'h0, v8}, 16'h0013);
      rd8(R_Z, v8);
      chk("jr1.z", {8'h0, v8}, 16'h0010);

      set8(R_Z, 8'hF0);
      idle();
      s_ab = RR_PCH_ZERO; idu = IDU_ADJ; adj_carry = 1'b0;
      s_rr_wb = WB_IDU; t_rr_wb = RR_WZ; t_db = R_Z; wr_data = 8'h10;
      tick();
      rd8(R_W, v8);
      chk("jr2.w", {8'h0, v8}, 16'h0011);

      set8(R_W, 8'hAB);
      set8(R_Z, 8'hFF);
      idle();
      s_rr_wb = WB_WZ; t_rr_wb = RR_AF; flags_we = 1'b1; flags_in = 4'h0;
      tick();
      rd8(R_A, v8);
      chk("pop.a", {8'h0, v8}, 16'h00AB);
      rd8(R_F, v8);
      chk("pop.f", {8'h0, v8}, 16'h00F0);
      chk("pop.flags", {12'h0, flags}, 16'h000F);

      set8(R_SPH, 8'hFF);
      set8(R_SPL, 8'hFE);
      set8(R_B, 8'h77);
      idle();
      s_ab = RR_SP; s_db = R_B; t_db = R_MEM; idu = IDU_DEC;
      s_rr_wb = WB_IDU; t_rr_wb = RR_SP;
      #1;
      chk("push.mem_we", {15'h0, mem_we}, 16'h0001);
      chk("push.addr", addr, 16'hFFFE);
      chk("push.rd", {8'h0, rd_data}, 16'h0077);
      tick();
      rd16(RR_SP, v16);
      chk("push.sp", v16, 16'hFFFD);
      check_all("push");

      for (int k = 0; k < 300; k++) begin
         rst = ($urandom_range(0, 24) != 0);
         s_ab = reg16_t'(3'($urandom_range(0, 7)));
         s_db = reg8_t'(4'($urandom_range(0, 15)));
         t_db = reg8_t'(4'($urandom_range(0, 15)));
         wr_data = 8'($urandom);
         idu = idu_mode_t'(2'($urandom_range(0, 2)));
         s_rr_wb = s_rr_wb_t'(2'($urandom_range(0, 2)));
         t_rr_wb = reg16_t'(3'($urandom_range(0, 7)));
         wr_pc = ($urandom_range(0, 3) == 0);
         adj_carry = 1'($urandom);
         flags_we = 1'($urandom);
         flags_in = 4'($urandom);
         #1;
         chk("rnd.addr", addr, 16'(m_addr(s_ab)));
         chk("rnd.rd", {8'h0, rd_data},
             {8'h0, (int'(s_db) < 14) ? m[int'(s_db)] : 8'h00});
         chk("rnd.mem_we", {15'h0, mem_we},
             {15'h0, rst && t_db == R_MEM});
         tick();
         rst = 1'b1;
         check_all($sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
